// File: rtl/movegen_cell.sv
// movegen_cell: one square of the systolic move-generator grid.
// Holds a 4-bit piece code loaded over the serial position chain.
// Exchanges combinational pawn/king/slider/knight/castle signals with its neighbours.
// A small snapshot stack supports make/unmake.
// A registered target latch with a valid/ack handshake reports move targets.
// In attack-map mode the square keeps a sticky "attacked" flag instead.
// Optional feature macro: MOVEGEN_PROMO_EN. When defined, pawn hits on the
// promotion rank latch class 7.
module movegen_cell #(
  parameter int RANK       = 1,
  parameter int FILE       = 1,
  parameter int BOARD_N    = 8,
  parameter int SNAP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_pos_valid,
  input  logic [3:0] in_pos_data,
  output logic [3:0] out_pos_data,
  input  logic       snap_push,
  input  logic       snap_pop,
  output logic       snap_full,
  output logic       snap_empty,
  input  logic       wtp,
  input  logic       mode,
  input  logic       emit_move,
  input  logic       eval,
  input  logic [3:0] i_castle_rights,
  input  logic [5:0] i_pawn,
  output logic [3:0] o_pawn,
  input  logic [7:0] i_king,
  output logic [7:0] o_king,
  input  logic [7:0] i_slide,
  output logic [7:0] o_slide,
  input  logic [7:0] i_knight,
  output logic [7:0] o_knight,
  input  logic [1:0] i_castle,
  output logic [1:0] o_castle,
  output logic       target_valid,
  output logic [2:0] target_class,
  input  logic       target_ack,
  output logic       attacked,
  input  logic       scan_clear
);

  // Target classes
  localparam logic [2:0] CLS_NONE    = 3'd0;
  localparam logic [2:0] CLS_PUSH    = 3'd1;
  localparam logic [2:0] CLS_CAPTURE = 3'd2;
  localparam logic [2:0] CLS_KNIGHT  = 3'd3;
  localparam logic [2:0] CLS_KING    = 3'd4;
  localparam logic [2:0] CLS_SLIDE   = 3'd5;
  localparam logic [2:0] CLS_CASTLE  = 3'd6;
`ifdef MOVEGEN_PROMO_EN
  localparam logic [2:0] CLS_PROMO   = 3'd7;
`endif

  // Square geometry, fixed at elaboration
  localparam bit CASTLE_RANK = (RANK == 1) || (RANK == BOARD_N);
  localparam bit KING_HOME   = CASTLE_RANK && (FILE == 5);
  localparam bit DPUSH_WHITE = (RANK == 3);
  localparam bit DPUSH_BLACK = (RANK == BOARD_N - 2);
  localparam bit CASTLE_E_TGT = CASTLE_RANK && !KING_HOME && (FILE == BOARD_N - 1);
  localparam bit CASTLE_W_TGT = CASTLE_RANK && !KING_HOME && (FILE == 2);
  localparam logic [2:0] DEPTH = 3'(SNAP_DEPTH);

  // Pawn bus bit positions: in {nw,sw,s,se,ne,n}, out {se_sw,ne_nw,s,n}
  localparam int PI_N  = 0;
  localparam int PI_NE = 1;
  localparam int PI_SE = 2;
  localparam int PI_S  = 3;
  localparam int PI_SW = 4;
  localparam int PI_NW = 5;
  localparam int PO_N     = 0;
  localparam int PO_S     = 1;
  localparam int PO_NE_NW = 2;
  localparam int PO_SE_SW = 3;
  // Castle bus: {w,e}
  localparam int CA_E = 0;
  localparam int CA_W = 1;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [2:0] class_reg, class_next;
  logic [3:0] pos_reg, pos_next;
  logic [2:0] count_reg, count_next;
  logic       attacked_reg, attacked_next;
  logic [3:0] stack_mem [0:3];

  // Piece decode
  logic is_empty, sq_oppos;
  logic is_king, is_knight, is_ortho, is_diag;
  logic is_wpawn, is_bpawn;

  assign is_empty  = (pos_reg[2:0] == 3'd0);
  assign sq_oppos  = !is_empty && (pos_reg[3] != wtp);
  assign is_king   = (pos_reg[2:0] == 3'd1);
  assign is_knight = (pos_reg[2:0] == 3'd5);
  assign is_ortho  = (pos_reg[2:0] == 3'd2) || (pos_reg[2:0] == 3'd3);
  assign is_diag   = (pos_reg[2:0] == 3'd2) || (pos_reg[2:0] == 3'd4);
  assign is_wpawn  = (pos_reg == 4'hE);
  assign is_bpawn  = (pos_reg == 4'h6);

  // ---------------------------------------------------------------------
  // Neighbour signal drivers
  // ---------------------------------------------------------------------

  // Pawn outputs: sourced by a pawn, double-push relayed by empty rank-3 / rank-(N-2) squares
  always_comb begin
    o_pawn = 4'b0000;
    if (emit_move && is_wpawn) begin
      o_pawn[PO_N]     = 1'b1;
      o_pawn[PO_NE_NW] = 1'b1;
    end
    if (emit_move && is_bpawn) begin
      o_pawn[PO_S]     = 1'b1;
      o_pawn[PO_SE_SW] = 1'b1;
    end
    if (DPUSH_WHITE && is_empty && i_pawn[PI_S]) begin
      o_pawn[PO_N] = 1'b1;
    end
    if (DPUSH_BLACK && is_empty && i_pawn[PI_N]) begin
      o_pawn[PO_S] = 1'b1;
    end
  end

  // Even bits are orthogonal rays, odd bits diagonal; a ray leaving in
  // direction d enters from the opposite side, bit (d+4)%8.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dir
      assign o_king[gi]   = emit_move && is_king;
      assign o_knight[gi] = emit_move && is_knight;
      if ((gi % 2) == 0) begin : g_ortho
        assign o_slide[gi] = (emit_move && is_ortho) || (is_empty && i_slide[(gi + 4) % 8]);
      end else begin : g_diag
        assign o_slide[gi] = (emit_move && is_diag) || (is_empty && i_slide[(gi + 4) % 8]);
      end
    end
  endgenerate

  // Castle: the king-home square sources rights, empty rank squares relay the signal
  always_comb begin
    o_castle = 2'b00;
    if (KING_HOME) begin
      if (emit_move && is_king) begin
        if (RANK == 1) begin
          o_castle[CA_W] = i_castle_rights[0];
          o_castle[CA_E] = i_castle_rights[1];
        end else begin
          o_castle[CA_W] = i_castle_rights[2];
          o_castle[CA_E] = i_castle_rights[3];
        end
      end
    end else if (CASTLE_RANK && is_empty) begin
      o_castle = i_castle;
    end
  end

  // ---------------------------------------------------------------------
  // Hit detection and class priority
  // ---------------------------------------------------------------------
  logic push_hit, cap_hit, knight_hit, king_hit, slide_hit, castle_hit, promo_hit;
  logic any_hit, attack_set;
  logic [2:0] hit_class;

  assign push_hit   = (i_pawn[PI_N] || i_pawn[PI_S]) && is_empty;
  assign cap_hit    = (i_pawn[PI_NE] || i_pawn[PI_SE] || i_pawn[PI_SW] || i_pawn[PI_NW]) && sq_oppos;
  assign knight_hit = (|i_knight) && (is_empty || sq_oppos);
  assign king_hit   = (|i_king) && (is_empty || sq_oppos);
  assign slide_hit  = (|i_slide) && (is_empty || sq_oppos);
  assign castle_hit = (CASTLE_E_TGT && i_castle[CA_W]) || (CASTLE_W_TGT && i_castle[CA_E]);
`ifdef MOVEGEN_PROMO_EN
  logic promo_rank;
  assign promo_rank = wtp ? (RANK == BOARD_N) : (RANK == 1);
  assign promo_hit  = (push_hit || cap_hit) && promo_rank;
`else
  assign promo_hit  = 1'b0;
`endif

  assign any_hit = push_hit || cap_hit || knight_hit || king_hit || slide_hit || castle_hit || promo_hit;

  // Attack map ignores occupancy; pushes and castling are not attacks
  assign attack_set = eval && mode &&
                      (i_pawn[PI_NE] || i_pawn[PI_SE] || i_pawn[PI_SW] || i_pawn[PI_NW] ||
                       (|i_king) || (|i_knight) || (|i_slide));

  // Class priority: promo > castle > capture > push > knight > king > slide
  always_comb begin
    hit_class = CLS_NONE;
`ifdef MOVEGEN_PROMO_EN
    if (promo_hit)       hit_class = CLS_PROMO;
    else
`endif
    if (castle_hit)      hit_class = CLS_CASTLE;
    else if (cap_hit)    hit_class = CLS_CAPTURE;
    else if (push_hit)   hit_class = CLS_PUSH;
    else if (knight_hit) hit_class = CLS_KNIGHT;
    else if (king_hit)   hit_class = CLS_KING;
    else if (slide_hit)  hit_class = CLS_SLIDE;
  end

  // ---------------------------------------------------------------------
  // Target latch FSM
  // ---------------------------------------------------------------------

  // Next state: capture once from IDLE, hold until acknowledged
  always_comb begin
    state_next = state_reg;
    class_next = class_reg;
    case (state_reg)
      S_IDLE: begin
        if (eval && !mode && any_hit) begin
          state_next = S_HOLD;
          class_next = hit_class;
        end
      end
      S_HOLD: begin
        if (target_ack) begin
          state_next = S_IDLE;
          class_next = CLS_NONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        class_next = CLS_NONE;
      end
    endcase
  end

  // FSM state and latched class
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      class_reg <= CLS_NONE;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
    end
  end

  assign target_valid = (state_reg == S_HOLD);
  assign target_class = class_reg;

  // Sticky attacked flag; a set in the same cycle beats scan_clear
  always_comb begin
    attacked_next = attacked_reg;
    if (attack_set)      attacked_next = 1'b1;
    else if (scan_clear) attacked_next = 1'b0;
  end

  // Attacked flag register
  always_ff @(posedge clk) begin
    if (rst) attacked_reg <= 1'b0;
    else     attacked_reg <= attacked_next;
  end

  assign attacked = attacked_reg;

  // ---------------------------------------------------------------------
  // Position register and snapshot stack
  // ---------------------------------------------------------------------
  logic       push_eff, pop_eff, pop_only;
  logic [1:0] wr_idx, top_idx;

  assign snap_full  = (count_reg == DEPTH);
  assign snap_empty = (count_reg == 3'd0);
  // A simultaneous push and pop cancel each other
  assign pop_only   = snap_pop && !snap_push;
  assign push_eff   = snap_push && !snap_pop && !snap_full;
  assign pop_eff    = pop_only && !snap_empty;
  assign wr_idx     = count_reg[1:0];
  assign top_idx    = count_reg[1:0] - 2'd1;

  // Pos selection: a pop request outranks a chain load; an empty-stack pop leaves pos alone
  always_comb begin
    pos_next   = pos_reg;
    count_next = count_reg;
    if (pop_eff) begin
      pos_next   = stack_mem[top_idx];
      count_next = count_reg - 3'd1;
    end else if (in_pos_valid && !pop_only) begin
      pos_next = in_pos_data;
    end
    if (push_eff) begin
      count_next = count_reg + 3'd1;
    end
  end

  // Stack storage; pushes save the pre-edge pos, so push+load keeps the old value
  always_ff @(posedge clk) begin
    if (push_eff) begin
      stack_mem[wr_idx] <= pos_reg;
    end
  end

  // Position and stack depth registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg   <= 4'h0;
      count_reg <= 3'd0;
    end else begin
      pos_reg   <= pos_next;
      count_reg <= count_next;
    end
  end

  assign out_pos_data = pos_reg;

endmodule

// File: tb/tb_movegen_cell.sv
// tb_movegen_cell: directed self-checking bench for movegen_cell.
// Three cells share stimulus: rank 3 file 4 (idx 0), rank 1 file 7 (idx 1),
// rank 8 file 1 (idx 2). Each scenario starts from a reset.
module tb_movegen_cell;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_pos_valid = 1'b0;
  logic [3:0] in_pos_data = 4'h0;
  logic       snap_push = 1'b0, snap_pop = 1'b0;
  logic       wtp = 1'b1, mode = 1'b0, emit_move = 1'b0, eval = 1'b0;
  logic [3:0] i_castle_rights = 4'h0;
  logic [5:0] i_pawn = 6'h0;
  logic [7:0] i_king = 8'h0, i_slide = 8'h0, i_knight = 8'h0;
  logic [1:0] i_castle = 2'b00;
  logic       target_ack = 1'b0, scan_clear = 1'b0;

  logic [3:0] out_pos      [3];
  logic       snap_full    [3];
  logic       snap_empty   [3];
  logic [3:0] o_pawn       [3];
  logic [7:0] o_king       [3];
  logic [7:0] o_slide      [3];
  logic [7:0] o_knight     [3];
  logic [1:0] o_castle     [3];
  logic       target_valid [3];
  logic [2:0] target_class [3];
  logic       attacked     [3];

  int checks = 0;
  int errors = 0;

`ifdef MOVEGEN_PROMO_EN
  localparam logic [2:0] PROMO_EXP = 3'd7;
`else
  localparam logic [2:0] PROMO_EXP = 3'd1;
`endif

  always #5 clk = ~clk;

  movegen_cell #(.RANK(3), .FILE(4), .BOARD_N(8), .SNAP_DEPTH(2)) u_r3 (
    .clk(clk), .rst(rst), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
    .out_pos_data(out_pos[0]), .snap_push(snap_push), .snap_pop(snap_pop),
    .snap_full(snap_full[0]), .snap_empty(snap_empty[0]), .wtp(wtp), .mode(mode),
    .emit_move(emit_move), .eval(eval), .i_castle_rights(i_castle_rights),
    .i_pawn(i_pawn), .o_pawn(o_pawn[0]), .i_king(i_king), .o_king(o_king[0]),
    .i_slide(i_slide), .o_slide(o_slide[0]), .i_knight(i_knight), .o_knight(o_knight[0]),
    .i_castle(i_castle), .o_castle(o_castle[0]), .target_valid(target_valid[0]),
    .target_class(target_class[0]), .target_ack(target_ack), .attacked(attacked[0]),
    .scan_clear(scan_clear));

  movegen_cell #(.RANK(1), .FILE(7), .BOARD_N(8), .SNAP_DEPTH(2)) u_r1 (
    .clk(clk), .rst(rst), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
    .out_pos_data(out_pos[1]), .snap_push(snap_push), .snap_pop(snap_pop),
    .snap_full(snap_full[1]), .snap_empty(snap_empty[1]), .wtp(wtp), .mode(mode),
    .emit_move(emit_move), .eval(eval), .i_castle_rights(i_castle_rights),
    .i_pawn(i_pawn), .o_pawn(o_pawn[1]), .i_king(i_king), .o_king(o_king[1]),
    .i_slide(i_slide), .o_slide(o_slide[1]), .i_knight(i_knight), .o_knight(o_knight[1]),
    .i_castle(i_castle), .o_castle(o_castle[1]), .target_valid(target_valid[1]),
    .target_class(target_class[1]), .target_ack(target_ack), .attacked(attacked[1]),
    .scan_clear(scan_clear));

  movegen_cell #(.RANK(8), .FILE(1), .BOARD_N(8), .SNAP_DEPTH(2)) u_r8 (
    .clk(clk), .rst(rst), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
    .out_pos_data(out_pos[2]), .snap_push(snap_push), .snap_pop(snap_pop),
    .snap_full(snap_full[2]), .snap_empty(snap_empty[2]), .wtp(wtp), .mode(mode),
    .emit_move(emit_move), .eval(eval), .i_castle_rights(i_castle_rights),
    .i_pawn(i_pawn), .o_pawn(o_pawn[2]), .i_king(i_king), .o_king(o_king[2]),
    .i_slide(i_slide), .o_slide(o_slide[2]), .i_knight(i_knight), .o_knight(o_knight[2]),
    .i_castle(i_castle), .o_castle(o_castle[2]), .target_valid(target_valid[2]),
    .target_class(target_class[2]), .target_ack(target_ack), .attacked(attacked[2]),
    .scan_clear(scan_clear));

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] d);
    in_pos_valid = 1'b1;
    in_pos_data  = d;
    tick();
    in_pos_valid = 1'b0;
    $display("txn load pos=%h", d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn reset");
    checks++; if (target_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", target_valid[0]); end
    checks++; if (target_class[0] !== 3'd0) begin errors++; $display("FAIL rst_class got=%0d exp=0", target_class[0]); end
    checks++; if (snap_empty[0] !== 1'b1 || snap_full[0] !== 1'b0) begin errors++; $display("FAIL rst_stack got empty=%b full=%b exp empty=1 full=0", snap_empty[0], snap_full[0]); end
    checks++; if (attacked[0] !== 1'b0) begin errors++; $display("FAIL rst_attacked got=%b exp=0", attacked[0]); end
    checks++; if (out_pos[0] !== 4'h0) begin errors++; $display("FAIL rst_pos got=%h exp=0", out_pos[0]); end
  endtask

  task automatic test_pawn_push;
    do_reset();
    load(4'h0);
    wtp = 1'b1;
    target_ack = 1'b1;          // ack in IDLE must be ignored
    tick();
    target_ack = 1'b0;
    $display("txn ack_in_idle");
    checks++; if (target_valid[0] !== 1'b0) begin errors++; $display("FAIL idle_ack got=%b exp=0", target_valid[0]); end
    i_pawn = 6'b001000;         // s
    #1;
    checks++; if (o_pawn[0] !== 4'b0001) begin errors++; $display("FAIL dpush_relay got=%b exp=0001", o_pawn[0]); end
    eval = 1'b1;
    tick();
    eval = 1'b0;
    i_pawn = 6'b0;
    $display("txn eval push");
    checks++; if (target_valid[0] !== 1'b1 || target_class[0] !== 3'd1) begin errors++; $display("FAIL push_latch got v=%b c=%0d exp v=1 c=1", target_valid[0], target_class[0]); end
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    $display("txn ack");
    checks++; if (target_valid[0] !== 1'b0 || target_class[0] !== 3'd0) begin errors++; $display("FAIL push_ack got v=%b c=%0d exp v=0 c=0", target_valid[0], target_class[0]); end
  endtask

  task automatic test_pawn_capture;
    do_reset();
    load(4'h6);
    wtp = 1'b1;
    emit_move = 1'b1;
    #1;
    checks++; if (o_pawn[0] !== 4'b1010) begin errors++; $display("FAIL bpawn_out got=%b exp=1010", o_pawn[0]); end
    emit_move = 1'b0;
    i_pawn  = 6'b000010;        // ne
    i_slide = 8'h01;            // n
    eval = 1'b1;
    tick();
    i_pawn = 6'b0;
    i_slide = 8'h0;
    $display("txn eval capture+slide");
    checks++; if (target_valid[0] !== 1'b1 || target_class[0] !== 3'd2) begin errors++; $display("FAIL cap_prio got v=%b c=%0d exp v=1 c=2", target_valid[0], target_class[0]); end
    i_knight = 8'h01;           // nne, eval still high during HOLD
    tick();
    eval = 1'b0;
    $display("txn eval in hold");
    checks++; if (target_valid[0] !== 1'b1 || target_class[0] !== 3'd2) begin errors++; $display("FAIL hold_no_overwrite got v=%b c=%0d exp v=1 c=2", target_valid[0], target_class[0]); end
    load(4'h0);
    checks++; if (target_class[0] !== 3'd2 || out_pos[0] !== 4'h0) begin errors++; $display("FAIL load_in_hold got c=%0d pos=%h exp c=2 pos=0", target_class[0], out_pos[0]); end
    target_ack = 1'b1;
    eval = 1'b1;
    tick();
    target_ack = 1'b0;
    eval = 1'b0;
    i_knight = 8'h0;
    $display("txn ack+eval");
    checks++; if (target_valid[0] !== 1'b0 || target_class[0] !== 3'd0) begin errors++; $display("FAIL ack_eval got v=%b c=%0d exp v=0 c=0", target_valid[0], target_class[0]); end
  endtask

  task automatic test_attack;
    do_reset();
    mode = 1'b1;
    i_pawn = 6'b000001;         // push only
    eval = 1'b1;
    tick();
    i_pawn = 6'b0;
    $display("txn attack push");
    checks++; if (attacked[0] !== 1'b0) begin errors++; $display("FAIL attack_push got=%b exp=0", attacked[0]); end
    i_knight = 8'h10;           // een
    tick();
    eval = 1'b0;
    $display("txn attack knight");
    checks++; if (attacked[0] !== 1'b1 || target_valid[0] !== 1'b0) begin errors++; $display("FAIL attack_set got a=%b v=%b exp a=1 v=0", attacked[0], target_valid[0]); end
    eval = 1'b1;
    scan_clear = 1'b1;
    tick();
    eval = 1'b0;
    i_knight = 8'h0;
    $display("txn clear+set");
    checks++; if (attacked[0] !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", attacked[0]); end
    tick();
    scan_clear = 1'b0;
    mode = 1'b0;
    $display("txn clear");
    checks++; if (attacked[0] !== 1'b0) begin errors++; $display("FAIL clear got=%b exp=0", attacked[0]); end
  endtask

  task automatic test_snapshot;
    do_reset();
    load(4'hB);
    snap_push = 1'b1; tick(); snap_push = 1'b0;
    load(4'h3);
    snap_push = 1'b1; tick(); snap_push = 1'b0;
    $display("txn push x2");
    checks++; if (snap_full[0] !== 1'b1 || snap_empty[0] !== 1'b0) begin errors++; $display("FAIL full got full=%b empty=%b exp full=1 empty=0", snap_full[0], snap_empty[0]); end
    load(4'h5);
    snap_push = 1'b1; tick(); snap_push = 1'b0;   // ignored
    load(4'h0);
    snap_pop = 1'b1; tick(); snap_pop = 1'b0;
    $display("txn pop");
    checks++; if (out_pos[0] !== 4'h3 || snap_full[0] !== 1'b0) begin errors++; $display("FAIL pop1 got pos=%h full=%b exp pos=3 full=0", out_pos[0], snap_full[0]); end
    snap_pop = 1'b1; tick(); snap_pop = 1'b0;
    $display("txn pop");
    checks++; if (out_pos[0] !== 4'hB || snap_empty[0] !== 1'b1) begin errors++; $display("FAIL pop2 got pos=%h empty=%b exp pos=b empty=1", out_pos[0], snap_empty[0]); end
    snap_pop = 1'b1; tick(); snap_pop = 1'b0;
    $display("txn pop empty");
    checks++; if (out_pos[0] !== 4'hB) begin errors++; $display("FAIL pop_empty got pos=%h exp pos=b", out_pos[0]); end
    snap_push = 1'b1; in_pos_valid = 1'b1; in_pos_data = 4'h9;
    tick();
    snap_push = 1'b0; in_pos_valid = 1'b0;
    $display("txn push+load");
    checks++; if (out_pos[0] !== 4'h9 || snap_empty[0] !== 1'b0) begin errors++; $display("FAIL push_load got pos=%h empty=%b exp pos=9 empty=0", out_pos[0], snap_empty[0]); end
    snap_push = 1'b1; snap_pop = 1'b1;
    tick();
    snap_push = 1'b0; snap_pop = 1'b0;
    $display("txn push+pop");
    checks++; if (out_pos[0] !== 4'h9 || snap_empty[0] !== 1'b0 || snap_full[0] !== 1'b0) begin errors++; $display("FAIL push_pop got pos=%h empty=%b full=%b exp pos=9 empty=0 full=0", out_pos[0], snap_empty[0], snap_full[0]); end
    snap_pop = 1'b1; in_pos_valid = 1'b1; in_pos_data = 4'h2;
    tick();
    snap_pop = 1'b0; in_pos_valid = 1'b0;
    $display("txn pop+load");
    checks++; if (out_pos[0] !== 4'hB || snap_empty[0] !== 1'b1) begin errors++; $display("FAIL pop_load got pos=%h empty=%b exp pos=b empty=1", out_pos[0], snap_empty[0]); end
  endtask

  task automatic test_castle;
    do_reset();
    wtp = 1'b1;
    i_castle = 2'b10;           // w
    #1;
    checks++; if (o_castle[1] !== 2'b10) begin errors++; $display("FAIL castle_relay got=%b exp=10", o_castle[1]); end
    eval = 1'b1;
    tick();
    eval = 1'b0;
    i_castle = 2'b00;
    $display("txn eval castle");
    checks++; if (target_valid[1] !== 1'b1 || target_class[1] !== 3'd6) begin errors++; $display("FAIL castle_latch got v=%b c=%0d exp v=1 c=6", target_valid[1], target_class[1]); end
  endtask

  task automatic test_promo;
    do_reset();
    snap_push = 1'b1; tick(); snap_push = 1'b0;
    checks++; if (snap_empty[2] !== 1'b0) begin errors++; $display("FAIL promo_stack got empty=%b exp=0", snap_empty[2]); end
    wtp = 1'b1;
    i_pawn = 6'b001000;         // s
    eval = 1'b1;
    tick();
    eval = 1'b0;
    i_pawn = 6'b0;
    $display("txn eval promo rank");
    checks++; if (target_valid[2] !== 1'b1 || target_class[2] !== PROMO_EXP) begin errors++; $display("FAIL promo_class got v=%b c=%0d exp v=1 c=%0d", target_valid[2], target_class[2], PROMO_EXP); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn reset in hold");
    checks++; if (target_valid[2] !== 1'b0 || target_class[2] !== 3'd0 || snap_empty[2] !== 1'b1) begin errors++; $display("FAIL rst_hold got v=%b c=%0d empty=%b exp v=0 c=0 empty=1", target_valid[2], target_class[2], snap_empty[2]); end
  endtask

  initial begin
    tick();
    test_reset();
    test_pawn_push();
    test_pawn_capture();
    test_attack();
    test_snapshot();
    test_castle();
    test_promo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/movegen_cell.md
Name: movegen_cell

Overview:
One square of the systolic move-generator array; the top level instantiates an 8x8 grid.
- Holds a 4-bit piece code loaded over the serial position chain.
- Drives and receives combinational pawn/king/slider/knight/castle signals to and from its neighbours.
- Adds a snapshot stack for make/unmake, a registered target-square latch with valid/ack handshake, and an attack-map mode with a sticky attacked flag.

Parameters:
RANK, 1, rank of this square (1..BOARD_N)
FILE, 1, file of this square (1..BOARD_N)
BOARD_N, 8, board edge length; sets pawn double-push ranks (3, BOARD_N-2), promotion ranks (1, BOARD_N), castle ranks (1, BOARD_N) and castle target files (2, BOARD_N-1)
SNAP_DEPTH, 2, snapshot stack entries (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_pos_valid  in  1  load strobe for the serial chain
in_pos_data  in  4  piece code; bit3 = white, bits2:0 = K1 Q2 R3 B4 N5 P6, 0 = empty
out_pos_data  out  4  current pos register, to the next chain stage
snap_push  in  1  push pos onto the stack
snap_pop  in  1  restore pos from the stack
snap_full  out  1  stack holds SNAP_DEPTH entries
snap_empty  out  1  stack holds 0 entries
wtp  in  1  side to play; 1 = white
mode  in  1  0 = move generation, 1 = attack map
emit_move  in  1  this square sources moves
eval  in  1  sample incoming signals this cycle
i_castle_rights  in  4  {e8_e, e8_w, e1_e, e1_w}
i_pawn / o_pawn  in 6 / out 4  in {nw,sw,s,se,ne,n}; out {se_sw,ne_nw,s,n}
i_king / o_king  in 8 / out 8  ordered {nw,w,sw,s,se,e,ne,n} (bit0 = n)
i_slide / o_slide  in 8 / out 8  same order as king
i_knight / o_knight  in 8 / out 8  {wws,wwn,ees,een,ssw,sse,nnw,nne}
i_castle / o_castle  in 2 / out 2  {w,e}
target_valid  out  1  latched target pending
target_class  out  3  class of the latched target
target_ack  in  1  consumer accepts the target
attacked  out  1  sticky attack-map flag
scan_clear  in  1  clear attacked

Behaviour:
- Reset: pos=0, stack empty, snap_empty=1, snap_full=0, FSM IDLE, target_valid=0, target_class=0, attacked=0.
- Neighbour outputs are combinational from pos, emit_move and the inputs.
- Pawn out: white pawn (0xE) drives n and ne_nw; black pawn (0x6) drives s and se_sw.
- Double push: an empty square on RANK 3 forwards i_pawn.s to o_pawn.n; an empty square on RANK BOARD_N-2 forwards i_pawn.n to o_pawn.s.
- Sliders: rook/queen drive orthogonal directions, bishop/queen drive diagonal directions; an empty square passes each ray straight through from the opposite input.
- Knight and king: all 8 outputs driven when emit_move and the matching piece.
- Castle, king-home square (FILE 5 on rank 1 or BOARD_N): sources o_castle from the matching i_castle_rights bits.
- Castle, other squares on the castle ranks: pass the signal on when empty. A castle hit is FILE BOARD_N-1 with i_castle.w, or FILE 2 with i_castle.e.
- Candidate hits (sq_oppos = occupied and colour != wtp):
  - pawn push: i_pawn n or s, and empty
  - pawn capture: any pawn diagonal, and sq_oppos
  - knight, king, slide: any input, and (empty or sq_oppos)
- target_class encoding: 0 none, 1 push, 2 pawn capture, 3 knight, 4 king, 5 slide, 6 castle, 7 promo.
- Class priority: 7 > 6 > 2 > 1 > 3 > 4 > 5.
- FSM IDLE: eval && mode==0 && any hit -> HOLD next cycle, target_valid=1, class latched.
- FSM HOLD: stays until target_ack, then IDLE with valid=0 and class=0 on the next edge.
  - eval during HOLD is ignored; no overwrite.
  - ack and eval in the same HOLD cycle: go to IDLE, no capture.
  - ack in IDLE is ignored.
- Attack mode: eval && mode==1 sets attacked when any pawn diagonal, king, knight or slide input is asserted, regardless of occupancy. FSM untouched. Pawn pushes and castle never set attacked.
- scan_clear with a set in the same cycle: set wins.
- Stack push: stores pos; ignored when full.
- Stack pop: pos <= top; ignored when empty, pos unchanged.
- push+pop in the same cycle: no-op.
- pop+in_pos_valid in the same cycle: pop wins.
- push+in_pos_valid in the same cycle: the old pos is pushed and the new pos is loaded.
- Loading pos during HOLD does not disturb the latched target.
- rst mid-HOLD or with a non-empty stack returns everything to reset values on that edge.

Optional Feature:
MOVEGEN_PROMO_EN
- Defined: a pawn push or pawn capture onto RANK BOARD_N (white) or RANK 1 (black) latches class 7.
- Undefined: class 7 is never produced; such hits latch as 1 or 2.

Test Plan:
- Load 0x0 at RANK 3 FILE 4, wtp=1, i_pawn.s=1 -> o_pawn.n=1; with eval, target_valid=1 and class=1 next cycle; ack -> valid=0 the cycle after.
- Load 0x6 (black pawn), wtp=1, i_pawn.ne=1, i_slide.n=1, eval -> class=2 (capture beats slide); second eval while HOLD with i_knight.nne -> class stays 2.
- mode=1, empty square, i_knight.een=1, eval -> attacked=1; scan_clear+eval same cycle -> attacked stays 1; scan_clear alone -> 0.
- SNAP_DEPTH=2: load 0xB, push; load 0x3, push -> snap_full=1; third push ignored; load 0x0, pop -> pos=0x3; pop -> 0xB, snap_empty=1; pop -> pos stays 0xB.
- RANK 1 FILE 7 empty, i_castle.w=1, eval -> class=6, o_castle.w=1.
- RANK 8, i_pawn.s=1, empty, wtp=1, eval -> class=7 with MOVEGEN_PROMO_EN, class=1 without; rst during HOLD -> valid=0 and class=0 next cycle.
